// File: rtl/div_pkg.sv
// Shared types and constants for the shift-subtract divider.
// Holds the FSM state encoding, the default widths and the saturated quotient value.
package div_pkg;

  localparam int DW_DEF = 32;
  localparam int CW_DEF = 6;

  localparam logic [DW_DEF-1:0] Q_SAT = '1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

endpackage

// File: rtl/div_shift_sub_if.sv
// Start/busy/done handshake and operand/result bus of the divider.
// The requester drives the operands and start; the divider drives status and results.
interface div_shift_sub_if #(
  parameter int DW = 32
);

  logic            start;
  logic [2*DW-1:0] dividend;
  logic [DW-1:0]   divisor;
  logic            busy;
  logic            done;
  logic [DW-1:0]   q;
  logic [DW-1:0]   r;
  logic            dz;
  logic            ovf;

  modport master (
    output start, dividend, divisor,
    input  busy, done, q, r, dz, ovf
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, q, r, dz, ovf
  );

endinterface

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in one dividend bit, try the subtract.
// No storage; the caller must keep rem < divisor for the result to fit in DW bits.
module div_step #(
  parameter int DW = 32
) (
  input  logic [DW-1:0] rem,
  input  logic          din,
  input  logic [DW-1:0] divisor,
  output logic [DW-1:0] rem_next,
  output logic          qbit
);

  logic [DW:0] cand;

  assign cand = {rem, din};
  // A no-borrow subtract is the same as cand >= divisor.
  assign qbit     = (cand >= {1'b0, divisor});
  assign rem_next = qbit ? DW'(cand - {1'b0, divisor}) : cand[DW-1:0];

endmodule

// File: rtl/div_shift_sub.sv
// Iterative unsigned 2*DW / DW restoring divider, one quotient bit per clock; done DW cycles after start.
// Start is ignored while busy; DIV_EXC_FAST_EN lets divide-by-zero and overflow skip the iterations.
module div_shift_sub
  import div_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int CW = CW_DEF
) (
  input logic           clk,
  input logic           rst,
  div_shift_sub_if.slave bus
);

  localparam logic [DW-1:0] SAT = {DW{1'b1}};

  state_t        state;
  logic [CW-1:0] cnt;
  logic [DW-1:0] rem;
  logic [DW-1:0] shf;
  logic [DW-1:0] dvs;
`ifndef DIV_EXC_FAST_EN
  logic          dz_l;
  logic          ovf_l;
  logic [DW-1:0] lo_q;
`endif

  logic [DW-1:0] hi;
  logic [DW-1:0] lo;
  logic          sdz;
  logic          sov;
  logic [DW-1:0] rem_nx;
  logic          qbit;
  logic          last;

  assign hi   = bus.dividend[2*DW-1:DW];
  assign lo   = bus.dividend[DW-1:0];
  assign sdz  = (bus.divisor == '0);
  assign sov  = !sdz && (hi >= bus.divisor);
  assign last = (cnt == CW'(DW - 1));

  div_step #(.DW(DW)) u_step (
    .rem      (rem),
    .din      (shf[DW-1]),
    .divisor  (dvs),
    .rem_next (rem_nx),
    .qbit     (qbit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      rem      <= '0;
      shf      <= '0;
      dvs      <= '0;
`ifndef DIV_EXC_FAST_EN
      dz_l     <= 1'b0;
      ovf_l    <= 1'b0;
      lo_q     <= '0;
`endif
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.q    <= '0;
      bus.r    <= '0;
      bus.dz   <= 1'b0;
      bus.ovf  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            rem      <= hi;
            shf      <= lo;
            dvs      <= bus.divisor;
            cnt      <= '0;
            bus.busy <= 1'b1;
`ifdef DIV_EXC_FAST_EN
            if (sdz || sov) begin
              state    <= DONE;
              bus.done <= 1'b1;
              bus.q    <= SAT;
              bus.r    <= sdz ? lo : '0;
              bus.dz   <= sdz;
              bus.ovf  <= sov;
            end else begin
              state <= CALC;
            end
`else
            dz_l  <= sdz;
            ovf_l <= sov;
            lo_q  <= lo;
            state <= CALC;
`endif
          end
        end
        CALC: begin
          rem <= rem_nx;
          shf <= {shf[DW-2:0], qbit};
          cnt <= cnt + CW'(1);
          if (last) begin
            state    <= DONE;
            bus.done <= 1'b1;
`ifdef DIV_EXC_FAST_EN
            bus.q    <= {shf[DW-2:0], qbit};
            bus.r    <= rem_nx;
            bus.dz   <= 1'b0;
            bus.ovf  <= 1'b0;
`else
            // Exceptions ran the full iteration count; their data is discarded here.
            bus.q    <= (dz_l || ovf_l) ? SAT : {shf[DW-2:0], qbit};
            bus.r    <= dz_l ? lo_q : (ovf_l ? '0 : rem_nx);
            bus.dz   <= dz_l;
            bus.ovf  <= ovf_l;
`endif
          end
        end
        DONE: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_shift_sub.sv
// Directed bench for div_shift_sub: latency, exceptions, ignored starts, reset abort, product round-trips.
// Results are compared against hand-computed values and the operands of a*b.
module tb_div_shift_sub;
  import div_pkg::*;

  localparam int DW = 32;
  localparam int TMO = 100;
`ifdef DIV_EXC_FAST_EN
  localparam int EXC_LAT  = 0;
  localparam int EXC_BUSY = 1;
`else
  localparam int EXC_LAT  = 32;
  localparam int EXC_BUSY = 33;
`endif

  logic clk = 1'b0;
  logic rst;

  int n_checks = 0;
  int n_errs   = 0;

  div_shift_sub_if #(.DW(DW)) bus ();

  div_shift_sub #(.DW(DW), .CW(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Leaves the bench at the negedge after the accepting edge, start low.
  task automatic pulse_start(input logic [63:0] dd, input logic [31:0] dv);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = dd;
    bus.divisor  = dv;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // lat = rising edges after the start edge until done is seen; bc = busy cycles up to and including done.
  task automatic wait_done(output int lat, output int bc);
    lat = 0;
    bc  = 0;
    while (!bus.done && lat < TMO) begin
      if (bus.busy) bc++;
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    if (bus.busy) bc++;
    check("done_timeout", 64'(lat >= TMO), 64'd0);
  endtask

  task automatic run_op(input logic [63:0] dd, input logic [31:0] dv, output int lat, output int bc);
    pulse_start(dd, dv);
    wait_done(lat, bc);
    @(posedge clk);
    @(negedge clk);
    check("busy_drop", 64'(bus.busy), 64'd0);
    check("done_pulse", 64'(bus.done), 64'd0);
  endtask

  initial begin
    int lat, bc, seen;
    logic [31:0] a, b;

    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_q", 64'(bus.q), 64'd0);
    check("rst_r", 64'(bus.r), 64'd0);
    check("rst_dz", 64'(bus.dz), 64'd0);
    check("rst_ovf", 64'(bus.ovf), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op(64'd1000, 32'd7, lat, bc);
    check("basic_lat", 64'(lat), 64'd32);
    check("basic_busy", 64'(bc), 64'd33);
    check("basic_q", 64'(bus.q), 64'd142);
    check("basic_r", 64'(bus.r), 64'd6);
    check("basic_dz", 64'(bus.dz), 64'd0);
    check("basic_ovf", 64'(bus.ovf), 64'd0);

    run_op(64'hFFFFFFFE_00000001, 32'hFFFFFFFF, lat, bc);
    check("max_lat", 64'(lat), 64'd32);
    check("max_q", 64'(bus.q), 64'hFFFFFFFF);
    check("max_r", 64'(bus.r), 64'd0);
    check("max_ovf", 64'(bus.ovf), 64'd0);
    check("max_dz", 64'(bus.dz), 64'd0);

    run_op(64'h0000_0000_1234_5678, 32'd0, lat, bc);
    check("dz_lat", 64'(lat), 64'(EXC_LAT));
    check("dz_busy", 64'(bc), 64'(EXC_BUSY));
    check("dz_flag", 64'(bus.dz), 64'd1);
    check("dz_ovf", 64'(bus.ovf), 64'd0);
    check("dz_q", 64'(bus.q), 64'(Q_SAT));
    check("dz_r", 64'(bus.r), 64'h12345678);

    run_op(64'h00000001_00000000, 32'd1, lat, bc);
    check("ovf_lat", 64'(lat), 64'(EXC_LAT));
    check("ovf_flag", 64'(bus.ovf), 64'd1);
    check("ovf_dz", 64'(bus.dz), 64'd0);
    check("ovf_q", 64'(bus.q), 64'(Q_SAT));
    check("ovf_r", 64'(bus.r), 64'd0);

    // Start held during the done cycle must not launch a new operation.
    pulse_start(64'd10, 32'd3);
    wait_done(lat, bc);
    bus.start    = 1'b1;
    bus.dividend = 64'd5;
    bus.divisor  = 32'd1;
    @(posedge clk);
    @(negedge clk);
    check("done_start_ign", 64'(bus.busy), 64'd0);
    bus.start = 1'b0;
    check("small_q", 64'(bus.q), 64'd3);
    check("small_r", 64'(bus.r), 64'd1);

    // Second start mid-operation is ignored.
    pulse_start(64'd1000, 32'd7);
    repeat (9) @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 64'd50;
    bus.divisor  = 32'd5;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(lat, bc);
    check("ign_q", 64'(bus.q), 64'd142);
    check("ign_r", 64'(bus.r), 64'd6);
    @(posedge clk);
    @(negedge clk);
    check("ign_idle", 64'(bus.busy), 64'd0);

    // Reset aborts an operation in flight.
    pulse_start(64'd12345, 32'd11);
    repeat (19) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_q", 64'(bus.q), 64'd0);
    check("abort_r", 64'(bus.r), 64'd0);
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_done", 64'(bus.done), 64'd0);
    check("abort_dz", 64'(bus.dz), 64'd0);
    check("abort_ovf", 64'(bus.ovf), 64'd0);
    seen = 0;
    repeat (2) begin
      @(negedge clk);
      if (bus.done) seen++;
    end
    rst = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) seen++;
    end
    check("abort_no_done", 64'(seen), 64'd0);
    run_op(64'd12345, 32'd11, lat, bc);
    check("post_rst_lat", 64'(lat), 64'd32);
    check("post_rst_q", 64'(bus.q), 64'd1122);
    check("post_rst_r", 64'(bus.r), 64'd3);

    a = 32'h0000_1234;
    b = 32'h0000_0001;
    for (int i = 0; i < 1000; i++) begin
      a = a + 32'h55;
      b = b + 32'ha7;
      if (b == 32'd0) b = 32'd1;
      run_op({32'd0, a} * {32'd0, b}, b, lat, bc);
      check("rt_q", 64'(bus.q), 64'(a));
      check("rt_r", 64'(bus.r), 64'd0);
    end
    check("rt_dz", 64'(bus.dz), 64'd0);
    check("rt_ovf", 64'(bus.ovf), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule

// File: doc/div_shift_sub.md
Name: div_shift_sub

Overview:
- Iterative unsigned restoring divider. It is the inverse of the shift-add multiplier: it takes a 2*DW-bit dividend, such as a multiplier product, and a DW-bit divisor.
- Returns a DW-bit quotient and a DW-bit remainder, one bit per clock.
- Sits beside the multiplier in the arithmetic test top, so products can be divided back to recover the operands.
- Start/busy/done handshake; outputs are held until the next accepted start.

Parameters:
- DW, 32, divisor/quotient/remainder width; dividend width is 2*DW.
- CW, 6, iteration counter width; must satisfy 2^CW > DW.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- start  in  1  request pulse; sampled only in IDLE
- dividend  in  2*DW  unsigned dividend, sampled with start
- divisor  in  DW  unsigned divisor, sampled with start
- busy  out  1  high from the start-accept edge until done drops
- done  out  1  one-cycle pulse; q, r and flags are valid from this cycle on
- q  out  DW  quotient
- r  out  DW  remainder
- dz  out  1  divide-by-zero flag
- ovf  out  1  quotient-overflow flag (dividend[2DW-1:DW] >= divisor, divisor != 0)

Behaviour:
- Reset (async, any state): state=IDLE; counter=0; busy=0, done=0, q=0, r=0, dz=0, ovf=0. Reset mid-operation aborts; no done is issued.
- States:
  - IDLE: wait for start.
  - CALC: DW iteration cycles.
  - DONE: one cycle; done=1.
- Transitions:
  - IDLE->CALC on start (edge E0).
  - CALC->DONE when the counter reaches DW (edge E_DW).
  - DONE->IDLE unconditionally.
- Capture at E0: internal remainder register (DW+1 bits) = {1'b0, dividend[2DW-1:DW]}; shift register = dividend[DW-1:0]; divisor latched; dz/ovf computed and latched; busy=1.
- Iteration at each CALC edge:
  - trial = {rem[DW-1:0], shift MSB} - {1'b0, divisor};
  - if no borrow: rem=trial and quotient bit 1, else rem unchanged-shifted and quotient bit 0;
  - the quotient bit shifts into the LSB of the shift register.
- Latency:
  - q/r/flags load at E_DW;
  - done=1 in the cycle between E_DW and E_DW+1;
  - busy drops at E_DW+1;
  - next start is accepted at E_DW+1 at earliest (start coincident with the done cycle is ignored).
- start while busy is ignored; inputs are not re-sampled.
- Outputs q, r, dz, ovf hold their values until loaded by the next completed operation.
- Exception results, regardless of iteration data:
  - dz=1: q = all ones, r = dividend[DW-1:0].
  - ovf=1: q = all ones, r = 0.
  - dz and ovf are never both 1.
- Normal case: q = floor(dividend/divisor), r = dividend mod divisor, exact, with r < divisor.
- Start at the cycle reset deasserts: accepted if rst is low at that edge.

Optional Feature:
- Macro: DIV_EXC_FAST_EN.
- Defined: an exception (dz or ovf) skips CALC: IDLE->DONE at E0. Done is high in the cycle after E0 with the saturated outputs; busy lasts 1 cycle.
- Undefined: exceptions run the full DW iterations. Latency is constant (done after E_DW) and outputs are still overridden with the saturated values and flags.
- Non-exception behaviour is identical in both builds.

Decomposition:
- Package div_pkg:
  - state enum {IDLE, CALC, DONE};
  - default DW/CW constants;
  - saturation constant Q_SAT (all ones, DW bits).
- Sub-module div_step: one combinational restoring step.
  - Inputs: rem, next dividend bit, divisor.
  - Outputs: new rem, quotient bit.
- Instantiated once in div_shift_sub, which holds the FSM, counter and registers.

Test Plan:
- dividend=1000, divisor=7, DW=32 -> done exactly 32 cycles after the start edge; q=142, r=6, dz=0, ovf=0, busy high 33 cycles.
- dividend=64'hFFFFFFFE_00000001, divisor=32'hFFFFFFFF -> q=32'hFFFFFFFF, r=0, ovf=0 (max product round-trip).
- divisor=0, dividend=64'h0000_0000_1234_5678 -> dz=1, q=32'hFFFFFFFF, r=32'h12345678.
  - With DIV_EXC_FAST_EN: done 1 cycle after start.
  - Without it: done after 32 cycles.
- dividend=64'h00000001_00000000, divisor=1 -> ovf=1, q=32'hFFFFFFFF, r=0.
- Second start pulse at cycle 10 of an operation with different operands -> ignored; first result unchanged. Then assert rst at cycle 20 of a new operation -> all outputs 0 immediately, no done, next start runs normally.
- Random loop: a, b from the multiplier stimulus increments (a+=32'h55, b+=32'ha7, b!=0), dividend=a*b -> q==a, r==0 for 1000 operations back-to-back.
